// File: rtl/pipe_reg_chain_pkg.sv
// Shared types for the pipe_reg_chain register chain.
// Per-stage update decision, evaluated every cycle when reset is inactive.
package pipe_reg_chain_pkg;

    typedef enum logic [1:0] {
        STG_HOLD  = 2'd0,   // downstream blocked: keep valid bit and data
        STG_LOAD  = 2'd1,   // take the upstream item
        STG_DRAIN = 2'd2    // clear valid bit, keep stale data (bubble or flush)
    } stg_op_e;

endpackage

// File: rtl/pipe_stage.sv
// One stage of the register chain: a valid bit plus a data register.
// The stage loads, drains or holds according to its ready input and flush.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             rdy_i,
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_data_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);

    stg_op_e          op;
    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    always_comb begin
        op = STG_HOLD;
        if (flush) begin
            op = STG_DRAIN;
        end else if (rdy_i) begin
            op = up_vld_i ? STG_LOAD : STG_DRAIN;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        case (op)
            STG_LOAD: begin
                v_d = 1'b1;
                d_d = up_data_i;
            end
            STG_DRAIN: v_d = 1'b0;
            default:   v_d = v_q;
        endcase
    end

    // Reset overrides flush and any load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign vld_o  = v_q;
    assign data_o = d_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic chain of DEPTH register stages with bubble collapse, flush and
// a combinational ready chain running from the output back to the input.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("pipe_reg_chain: DEPTH must be at least 1");
        end
    endgenerate

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    logic [OCC_W-1:0] occ;

    // A stage can accept when it is empty or its own item moves on.
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i+1];
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(v[i]);
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic             up_vld;
            logic [WIDTH-1:0] up_data;

            if (g == 0) begin : g_head
                assign up_vld  = in_valid && !flush;
                assign up_data = in_data;
            end else begin : g_body
                assign up_vld  = v[g-1];
                assign up_data = d[g-1];
            end

            pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .rdy_i     (rdy[g]),
                .up_vld_i  (up_vld),
                .up_data_i (up_data),
                .vld_o     (v[g]),
                .data_o    (d[g])
            );
        end
    endgenerate

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign occupancy = occ;

endmodule
